// File: rtl/demux1_2_if.sv
// demux1_2_if: serial input and deserialized channel outputs of the 1:2 demux.
interface demux1_2_if #(parameter int WIDTH = 8);
  logic in, in_valid, sel, sync;
  logic [WIDTH-1:0] out1, out2;
  logic out1_valid, out2_valid, err;
  modport master(output in, in_valid, sel, sync, input out1, out2, out1_valid, out2_valid, err);
  modport slave(input in, in_valid, sel, sync, output out1, out2, out1_valid, out2_valid, err);
endinterface

// File: rtl/demux1_2.sv
// demux1_2: splits a sync-framed serial stream into two MSB-first WIDTH-bit channel words.
// Define DEMUX_PARITY_EN to expect a trailing even-parity bit after each channel word.
module demux1_2 #(
  parameter int WIDTH = 8
) (
  input logic sys_clk,
  input logic sys_rst_n,
  demux1_2_if.slave bus
);
`ifdef DEMUX_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam int CW = $clog2(LAST + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [1:0][WIDTH-1:0] sr, sr_n, word, word_n;
  logic [1:0][CW-1:0] cnt, cnt_n;
  logic [1:0] vld, vld_n;
  logic err, err_n, take;
  // index 0 is channel 1 (sel=1), index 1 is channel 2 (sel=0)
  always_comb begin
    state_n = (state == IDLE && bus.sync) ? RUN : state;
    take = bus.in_valid && (state == RUN || bus.sync);
    err_n = state == RUN && bus.sync && (cnt[0] != '0 || cnt[1] != '0);
    sr_n = bus.sync ? '0 : sr;
    cnt_n = bus.sync ? '0 : cnt;
    word_n = word;
    vld_n = '0;
    for (int c = 0; c < 2; c++) begin
      if (take && bus.sel == (c == 0)) begin
        if (cnt_n[c] == CW'(LAST)) begin
`ifdef DEMUX_PARITY_EN
          vld_n[c] = ~(^sr_n[c] ^ bus.in);
          err_n = err_n | ~vld_n[c];
          word_n[c] = vld_n[c] ? sr_n[c] : word[c];
`else
          vld_n[c] = 1'b1;
          word_n[c] = {sr_n[c][WIDTH-2:0], bus.in};
`endif
          cnt_n[c] = '0;
          sr_n[c] = '0;
        end else begin
          sr_n[c] = {sr_n[c][WIDTH-2:0], bus.in};
          cnt_n[c] = cnt_n[c] + CW'(1);
        end
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      word <= '0;
      vld <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      word <= word_n;
      vld <= vld_n;
      err <= err_n;
    end
  end
  assign bus.out1 = word[0];
  assign bus.out2 = word[1];
  assign bus.out1_valid = vld[0];
  assign bus.out2_valid = vld[1];
  assign bus.err = err;
endmodule

// File: tb/tb_demux1_2.sv
// tb_demux1_2: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_demux1_2;
  localparam int W = 8;
`ifdef DEMUX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  demux1_2_if #(.WIDTH(W)) bus ();
  demux1_2 #(.WIDTH(W)) dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  typedef struct {
    int kind;
    logic [W-1:0] data;
    int cyc;
  } ev_t;
  ev_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;
  function automatic logic bitof(input logic [W-1:0] d, input int i);
    return i < W ? d[W-1-i] : ^d;
  endfunction
  task automatic push(input int kind, input logic [W-1:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc = cyc;
    q.push_back(e);
  endtask
  task automatic observe(input int kind, input logic [W-1:0] data);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%h cyc=%0d, none expected", kind, data, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.data != data || e.cyc != cyc) begin
      errors++;
      $display("FAIL event: got kind=%0d data=%h cyc=%0d, want kind=%0d data=%h cyc=%0d",
               kind, data, cyc, e.kind, e.data, e.cyc);
    end
  endtask
  always @(negedge sys_clk) begin
    if (sys_rst_n && (bus.out1_valid || bus.out2_valid || bus.err)) begin
      checks++;
      if (bus.out1_valid && bus.out2_valid) begin
        errors++;
        $display("FAIL valid_overlap: both valids high at cyc=%0d, want at most one", cyc);
      end
      if (bus.out1_valid) observe(1, bus.out1);
      if (bus.out2_valid) observe(2, bus.out2);
      if (bus.err) observe(3, '0);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic b, input logic s, input logic sy);
    bus.in_valid = v;
    bus.in = b;
    bus.sel = s;
    bus.sync = sy;
    @(posedge sys_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.sync = 1'b0;
  endtask
  task automatic send_word(input logic s, input logic [W-1:0] d, input bit gaps);
    for (int i = 0; i < NB; i++) begin
      step(1'b1, bitof(d, i), s, 1'b0);
      if (i == NB - 1) push(s ? 1 : 2, d);
      if (gaps) repeat ((i % 5) + 1) step(1'b0, 1'b1, ~s, 1'b0);
    end
  endtask
  initial begin
    bus.in = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel = 1'b0;
    bus.sync = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    chk("rst_out1", 32'(bus.out1), 0);
    chk("rst_out2", 32'(bus.out2), 0);
    chk("rst_out1_valid", 32'(bus.out1_valid), 0);
    chk("rst_out2_valid", 32'(bus.out2_valid), 0);
    chk("rst_err", 32'(bus.err), 0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i[0], 1'b0);
    chk("nosync_out1", 32'(bus.out1), 0);
    chk("nosync_out2", 32'(bus.out2), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(1'b1, 8'hA5, 1'b0);
    chk("ch1_out1", 32'(bus.out1), 32'hA5);
    chk("ch1_out2", 32'(bus.out2), 0);
    for (int i = 0; i < NB; i++) begin
      step(1'b1, bitof(8'h3C, i), 1'b1, 1'b0);
      if (i == NB - 1) push(1, 8'h3C);
      step(1'b1, bitof(8'hC3, i), 1'b0, 1'b0);
      if (i == NB - 1) push(2, 8'hC3);
    end
    chk("intl_out1", 32'(bus.out1), 32'h3C);
    chk("intl_out2", 32'(bus.out2), 32'hC3);
    send_word(1'b0, 8'h81, 1'b1);
    chk("gap_out2", 32'(bus.out2), 32'h81);
    chk("gap_out1", 32'(bus.out1), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    push(3, '0);
    for (int i = 1; i < NB; i++) begin
      step(1'b1, bitof(8'h80, i), 1'b1, 1'b0);
      if (i == NB - 1) push(1, 8'h80);
    end
    chk("frame_out1", 32'(bus.out1), 32'h80);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    push(3, '0);
    chk("frame2_out2", 32'(bus.out2), 32'h81);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    sys_rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    sys_rst_n = 1'b1;
    chk("midrst_out1", 32'(bus.out1), 0);
    chk("midrst_out2", 32'(bus.out2), 0);
    for (int i = 0; i < NB; i++) step(1'b1, bitof(8'hFF, i), 1'b1, 1'b0);
    chk("idle_again_out1", 32'(bus.out1), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(1'b1, 8'h5A, 1'b0);
    chk("resync_out1", 32'(bus.out1), 32'h5A);
`ifdef DEMUX_PARITY_EN
    send_word(1'b1, 8'hA5, 1'b0);
    chk("par_ok_out1", 32'(bus.out1), 32'hA5);
    for (int i = 0; i < W; i++) step(1'b1, bitof(8'h01, i), 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    push(3, '0);
    chk("par_bad_out1", 32'(bus.out1), 32'hA5);
`endif
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
